// File: rtl/qcw_burst_sequencer.sv
// QCW burst sequencer: schedules PLL start pulses, ramps the phase shift inside a burst,
// and turns done/fault outcomes into cooldown, abort and lockout behaviour.
module qcw_burst_sequencer #(
    parameter int unsigned MIN_OFF       = 32'd5000,
    parameter int unsigned COOLDOWN      = 32'd1000000,
    parameter int unsigned FAULT_RETRIES = 32'd3,
    parameter int unsigned WATCHDOG      = 32'd1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        fire,
    input  logic [23:0] burst_period,
    input  logic [15:0] cycle_limit_in,
    input  logic [7:0]  ramp_start,
    input  logic [7:0]  ramp_end,
    input  logic [7:0]  ramp_rate,
    input  logic        pll_cycle_finished,
    input  logic        pll_done,
    input  logic        pll_fault,
    output logic        pll_start,
    output logic        pll_halt,
    output logic [7:0]  pll_phase_shift,
    output logic [15:0] pll_cycle_limit,
    output logic        busy,
    output logic        locked_out,
    output logic [3:0]  fault_count,
    output logic [15:0] burst_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_START   = 3'd2,
        ST_RUN     = 3'd3,
        ST_ABORT   = 3'd4,
        ST_COOL    = 3'd5,
        ST_LOCKOUT = 3'd6
    } state_t;

    localparam logic [3:0] RETRIES_4 = 4'(FAULT_RETRIES);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        done_q_r;
    logic        fault_q_r;
    logic        done_rise_s;
    logic        fault_rise_s;
    logic [23:0] period_timer_r;
    logic [31:0] off_timer_r;
    logic [31:0] watchdog_r;
    logic [31:0] cool_r;
    logic [15:0] acc_r;
    logic [15:0] acc_nxt_s;
    logic [15:0] ceil_s;
    logic [16:0] sum_s;
    logic [3:0]  fault_inc_s;
    logic        period_hit_s;
    logic        launch_s;
    logic        wd_expired_s;
    logic        cool_done_s;
    logic        off_clr_s;
    logic        run_fault_s;
    logic        run_done_s;

    assign done_rise_s  = pll_done & ~done_q_r;
    assign fault_rise_s = pll_fault & ~fault_q_r;
    assign fault_inc_s  = (fault_count == 4'd15) ? 4'd15 : (fault_count + 4'd1);
    assign wd_expired_s = (watchdog_r >= WATCHDOG);
    assign cool_done_s  = (cool_r >= (COOLDOWN - 32'd1));
    // The START cycle itself is timer value 0, so firing at period-1 spaces starts exactly burst_period apart.
    assign period_hit_s = (burst_period != 24'd0) ? (period_timer_r >= (burst_period - 24'd1)) : fire;
    assign launch_s     = period_hit_s && (off_timer_r >= MIN_OFF) && (cycle_limit_in != 16'd0);
    assign run_fault_s  = (state_r == ST_RUN) && fault_rise_s;
    assign run_done_s   = (state_r == ST_RUN) && !fault_rise_s && done_rise_s;

    // Next-state selection and off-timer restart events.
    always_comb begin
        state_nxt_s = state_r;
        off_clr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && (cycle_limit_in != 16'd0)) state_nxt_s = ST_WAIT;
                else state_nxt_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (!enable) state_nxt_s = ST_IDLE;
                else if (launch_s) state_nxt_s = ST_START;
                else state_nxt_s = ST_WAIT;
            end
            ST_START: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (fault_rise_s) begin
                    if (fault_inc_s >= RETRIES_4) state_nxt_s = ST_LOCKOUT;
                    else state_nxt_s = ST_COOL;
                end else if (done_rise_s) begin
                    state_nxt_s = ST_WAIT;
                    off_clr_s   = 1'b1;
                end else if (!enable || wd_expired_s) begin
                    state_nxt_s = ST_ABORT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_ABORT: begin
                if (fault_rise_s || done_rise_s) begin
                    off_clr_s = 1'b1;
                    if (enable) state_nxt_s = ST_COOL;
                    else state_nxt_s = ST_IDLE;
                end else if (wd_expired_s) begin
                    state_nxt_s = ST_LOCKOUT;
                end else begin
                    state_nxt_s = ST_ABORT;
                end
            end
            ST_COOL: begin
                if (cool_done_s) begin
                    off_clr_s = 1'b1;
                    if (enable) state_nxt_s = ST_WAIT;
                    else state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_COOL;
                end
            end
            ST_LOCKOUT: begin
                if (!enable) state_nxt_s = ST_IDLE;
                else state_nxt_s = ST_LOCKOUT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // 8.8 phase accumulator: loaded at burst start, ramped per osc cycle and clamped at the ceiling.
    always_comb begin
        ceil_s    = {ramp_end, 8'h00};
        sum_s     = {1'b0, acc_r} + {9'd0, ramp_rate};
        acc_nxt_s = acc_r;
        if (state_nxt_s == ST_START) begin
            acc_nxt_s = {ramp_start, 8'h00};
        end else if ((state_r == ST_RUN) && pll_cycle_finished && (ramp_end > ramp_start)) begin
            if (sum_s > {1'b0, ceil_s}) acc_nxt_s = ceil_s;
            else acc_nxt_s = sum_s[15:0];
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // State register and PLL status edge detectors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            done_q_r  <= 1'b0;
            fault_q_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            done_q_r  <= pll_done;
            fault_q_r <= pll_fault;
        end
    end

    // Period, off-time, watchdog and cooldown timers (all saturate rather than wrap).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_timer_r <= 24'd0;
            off_timer_r    <= 32'd0;
            watchdog_r     <= 32'd0;
            cool_r         <= 32'd0;
        end else begin
            if (state_nxt_s == ST_START) period_timer_r <= 24'd0;
            else if (period_timer_r != 24'hFF_FFFF) period_timer_r <= period_timer_r + 24'd1;

            if (off_clr_s) off_timer_r <= 32'd0;
            else if (off_timer_r < MIN_OFF) off_timer_r <= off_timer_r + 32'd1;

            if ((state_nxt_s == ST_START) || ((state_nxt_s == ST_ABORT) && (state_r != ST_ABORT)))
                watchdog_r <= 32'd0;
            else if (((state_r == ST_RUN) || (state_r == ST_ABORT)) && !wd_expired_s)
                watchdog_r <= watchdog_r + 32'd1;

            if (state_r == ST_COOL) cool_r <= cool_r + 32'd1;
            else cool_r <= 32'd0;
        end
    end

    // Registered outputs, aligned with the state they describe; counters for faults and bursts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r           <= 16'd0;
            pll_phase_shift <= 8'd0;
            pll_start       <= 1'b0;
            pll_halt        <= 1'b0;
            busy            <= 1'b0;
            locked_out      <= 1'b0;
            pll_cycle_limit <= 16'd0;
            fault_count     <= 4'd0;
            burst_count     <= 16'd0;
        end else begin
            acc_r           <= acc_nxt_s;
            pll_phase_shift <= acc_nxt_s[15:8];
            pll_start       <= (state_nxt_s == ST_START);
            pll_halt        <= (state_nxt_s == ST_ABORT);
            busy            <= (state_nxt_s == ST_START) || (state_nxt_s == ST_RUN) ||
                               (state_nxt_s == ST_ABORT);
            locked_out      <= (state_nxt_s == ST_LOCKOUT);
            if (state_nxt_s == ST_START) pll_cycle_limit <= cycle_limit_in;
            if (run_fault_s) fault_count <= fault_inc_s;
            else if (run_done_s || ((state_r == ST_LOCKOUT) && !enable)) fault_count <= 4'd0;
            if (run_done_s) burst_count <= burst_count + 16'd1;
        end
    end

endmodule
